// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with run-time reloadable pattern,
// fill-gated matching, registered match pulse and saturating hit counter.
module seq_detect_param #(
  parameter int                 SEQ_LEN   = 4,
  parameter logic [SEQ_LEN-1:0] SEQ_INIT  = 4'b1011,
  parameter int                 CNT_WIDTH = 5,
  parameter int                 OVERLAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 pat_load,
  input  logic [SEQ_LEN-1:0]   pat_in,
  input  logic                 cnt_clr,
  output logic                 match,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 cnt_sat,
  output logic [SEQ_LEN-1:0]   pat_q
);

  localparam int                   FW        = $clog2(SEQ_LEN + 1);
  localparam logic [FW-1:0]        FILL_FULL = FW'(SEQ_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [SEQ_LEN-1:0]   r_hist;
  logic [FW-1:0]        r_fill;
  logic [SEQ_LEN-1:0]   r_pat;
  logic                 r_match;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_sat;

  logic [SEQ_LEN-1:0]   w_hist_n;
  logic [FW-1:0]        w_fill_n;
  logic                 w_sample;
  logic                 w_hit;
  logic [CNT_WIDTH-1:0] w_count_inc;

  always_comb begin
    w_hist_n    = {r_hist[SEQ_LEN-2:0], din};
    w_fill_n    = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
    w_sample    = din_valid && !pat_load;
    // Fill gating keeps the zeroed history from matching an all-zero pattern.
    w_hit       = w_sample && (w_fill_n == FILL_FULL) && (w_hist_n == r_pat);
    w_count_inc = r_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= SEQ_INIT;
      r_match <= 1'b0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (pat_load) begin
        r_pat  <= pat_in;
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        if (din_valid) begin
          r_hist <= w_hist_n;
          r_fill <= (w_hit && (OVERLAP == 0)) ? '0 : w_fill_n;
        end
        // Clear beats a coincident hit; the match pulse is unaffected.
        if (cnt_clr) begin
          r_count <= '0;
          r_sat   <= 1'b0;
        end else if (w_hit && (r_count != CNT_MAX)) begin
          r_count <= w_count_inc;
          if (w_count_inc == CNT_MAX) r_sat <= 1'b1;
        end
      end
    end
  end

  assign match   = r_match;
  assign count   = r_count;
  assign cnt_sat = r_sat;
  assign pat_q   = r_pat;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default/overlap, non-overlap and
// short-pattern/narrow-counter instances driven from one linear sequence.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst, din, din_valid, cnt_clr;
  logic       pat_load_ab, pat_load_c;
  logic [3:0] pat_in_ab;
  logic [1:0] pat_in_c;

  logic       match_a, sat_a, match_b, sat_b, match_c, sat_c;
  logic [4:0] count_a, count_b;
  logic [2:0] count_c;
  logic [3:0] pat_q_a, pat_q_b;
  logic [1:0] pat_q_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_param u_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .pat_load(pat_load_ab), .pat_in(pat_in_ab), .cnt_clr(cnt_clr),
    .match(match_a), .count(count_a), .cnt_sat(sat_a), .pat_q(pat_q_a)
  );

  seq_detect_param #(.OVERLAP(0)) u_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .pat_load(pat_load_ab), .pat_in(pat_in_ab), .cnt_clr(cnt_clr),
    .match(match_b), .count(count_b), .cnt_sat(sat_b), .pat_q(pat_q_b)
  );

  seq_detect_param #(.SEQ_LEN(2), .SEQ_INIT(2'b11), .CNT_WIDTH(3)) u_c (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .pat_load(pat_load_c), .pat_in(pat_in_c), .cnt_clr(cnt_clr),
    .match(match_c), .count(count_c), .cnt_sat(sat_c), .pat_q(pat_q_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; cnt_clr = 1'b0;
    pat_load_ab = 1'b0; pat_load_c = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic b);
    din = b; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] stream;
    logic [6:0] exp_a;
    logic [6:0] exp_b;
    pat_in_ab = 4'b0000;
    pat_in_c  = 2'b00;

    // Reset state
    do_reset();
    chk("rst_match_a", 32'(match_a), 32'd0);
    chk("rst_count_a", 32'(count_a), 32'd0);
    chk("rst_sat_a",   32'(sat_a),   32'd0);
    chk("rst_pat_a",   32'(pat_q_a), 32'hB);
    chk("rst_pat_c",   32'(pat_q_c), 32'h3);

    // Overlap (u_a) vs non-overlap (u_b) on 1,0,1,1,0,1,1
    stream = 7'b1011011;
    exp_a  = 7'b0001001;
    exp_b  = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      send(stream[i]);
      chk($sformatf("ovl_match_a_bit%0d", 7 - i), 32'(match_a), 32'(exp_a[i]));
      chk($sformatf("novl_match_b_bit%0d", 7 - i), 32'(match_b), 32'(exp_b[i]));
    end
    tick();
    chk("ovl_match_idle_a", 32'(match_a), 32'd0);
    chk("ovl_count_a",      32'(count_a), 32'd2);
    chk("ovl_sat_a",        32'(sat_a),   32'd0);
    chk("novl_count_b",     32'(count_b), 32'd1);

    // Fill gating with all-zero pattern
    do_reset();
    pat_in_ab = 4'b0000; pat_load_ab = 1'b1;
    tick();
    pat_load_ab = 1'b0;
    chk("zero_pat_q_a", 32'(pat_q_a), 32'h0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0);
      chk($sformatf("zero_nomatch_%0d", i), 32'(match_a), 32'd0);
    end
    send(1'b0);
    chk("zero_match4",  32'(match_a), 32'd1);
    chk("zero_count_a", 32'(count_a), 32'd1);

    // Valid gating: idle cycles with toggling din are ignored
    do_reset();
    send(1'b1); send(1'b0); send(1'b1);
    for (int i = 0; i < 5; i++) begin
      din = i[0]; din_valid = 1'b0;
      tick();
      chk($sformatf("vg_idle_%0d", i), 32'(match_a), 32'd0);
    end
    send(1'b1);
    chk("vg_match", 32'(match_a), 32'd1);
    tick();
    chk("vg_match_drop", 32'(match_a), 32'd0);
    chk("vg_count_a",    32'(count_a), 32'd1);

    // Saturation and clear on u_c (pattern 11, 3-bit counter)
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      send(1'b1);
      chk($sformatf("sat_match_bit%0d", i), 32'(match_c), (i == 1) ? 32'd0 : 32'd1);
    end
    chk("sat_count_c", 32'(count_c), 32'd7);
    chk("sat_flag_c",  32'(sat_c),   32'd1);
    cnt_clr = 1'b1;
    send(1'b1);
    cnt_clr = 1'b0;
    chk("clr_hit_match_c", 32'(match_c), 32'd1);
    chk("clr_hit_count_c", 32'(count_c), 32'd0);
    chk("clr_hit_sat_c",   32'(sat_c),   32'd0);
    send(1'b1);
    chk("post_clr_count_c", 32'(count_c), 32'd1);

    // Pattern reload mid-stream preserves count
    do_reset();
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    chk("ld_pre_match", 32'(match_a), 32'd1);
    send(1'b1); send(1'b0); send(1'b1);
    chk("ld_pre_count", 32'(count_a), 32'd1);
    pat_in_ab = 4'b0110; pat_load_ab = 1'b1; din = 1'b1; din_valid = 1'b1;
    tick();
    pat_load_ab = 1'b0; din_valid = 1'b0;
    chk("ld_cycle_match", 32'(match_a), 32'd0);
    chk("ld_pat_q",       32'(pat_q_a), 32'h6);
    chk("ld_count_kept",  32'(count_a), 32'd1);
    send(1'b0); send(1'b1); send(1'b1);
    chk("ld_nomatch3", 32'(match_a), 32'd0);
    send(1'b0);
    chk("ld_match",       32'(match_a), 32'd1);
    chk("ld_count_after", 32'(count_a), 32'd2);

    // Reset mid-stream discards partial pattern
    do_reset();
    send(1'b1); send(1'b0); send(1'b1);
    do_reset();
    send(1'b1);
    chk("rstmid_match", 32'(match_a), 32'd0);
    chk("rstmid_count", 32'(count_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
